// File: rtl/shuffle_index_sequencer_if.sv
// Bus between the shuffle index sequencer, its configuring host, the permutation
// shuffler and the index consumer. Signal suffixes are from the sequencer's view.
interface shuffle_index_sequencer_if #(
   parameter int BITS_PER_ELEMENT = 7,
   parameter int PASS_BITS        = 8
);
   logic                        cfg_valid_i;
   logic [BITS_PER_ELEMENT-1:0] cfg_num_i;
   logic [PASS_BITS-1:0]        cfg_passes_i;
   logic                        cfg_ready_o;
   logic                        abort_i;
   logic [BITS_PER_ELEMENT-1:0] num_elements_o;
   logic                        rst_index_o;
   logic                        perm_req_o;
   logic                        perm_done_i;
   logic [BITS_PER_ELEMENT-1:0] addr_o;
   logic [BITS_PER_ELEMENT-1:0] data_i;
   logic                        idx_valid_o;
   logic                        idx_ready_i;
   logic [BITS_PER_ELEMENT-1:0] idx_data_o;
   logic                        idx_last_o;
   logic                        done_o;

   modport master (
      input  cfg_valid_i, cfg_num_i, cfg_passes_i, abort_i, perm_done_i, data_i, idx_ready_i,
      output cfg_ready_o, num_elements_o, rst_index_o, perm_req_o, addr_o,
             idx_valid_o, idx_data_o, idx_last_o, done_o
   );

   modport slave (
      output cfg_valid_i, cfg_num_i, cfg_passes_i, abort_i, perm_done_i, data_i, idx_ready_i,
      input  cfg_ready_o, num_elements_o, rst_index_o, perm_req_o, addr_o,
             idx_valid_o, idx_data_o, idx_last_o, done_o
   );
endinterface

// File: rtl/shuffle_index_sequencer.sv
// Sequences multi-pass shuffled loop indices: drives the permutation shuffler and
// streams its permuted output bank as an index stream.
module shuffle_index_sequencer #(
   parameter int MAX_ELEMENTS     = 128,
   parameter int BITS_PER_ELEMENT = $clog2(MAX_ELEMENTS),
   parameter int PASS_BITS        = 8
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   shuffle_index_sequencer_if.master bus,
   output logic [2:0]              dbg_state
);
   // Index stream: a word transfers on a rising edge where idx_valid_o and
   // idx_ready_i are both high; once valid is raised, data/last hold until transfer.

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] LOAD      = 3'd1;
   localparam logic [2:0] WAIT_PERM = 3'd2;
   localparam logic [2:0] REQ       = 3'd3;
   localparam logic [2:0] SETTLE    = 3'd4;
   localparam logic [2:0] STREAM    = 3'd5;
   localparam logic [2:0] DRAIN     = 3'd6;

   logic [2:0]                  state;
   logic [BITS_PER_ELEMENT-1:0] num_q;
   logic [BITS_PER_ELEMENT-1:0] elem_cnt;
   logic [BITS_PER_ELEMENT-1:0] data_q;
   logic [PASS_BITS-1:0]        pass_cnt;
   logic [PASS_BITS-1:0]        pass_lim;
   logic                        perm_ready;
   logic                        valid_q;
   logic                        last_q;
   logic                        done_q;
   logic                        load;
   logic                        last_elem;

   assign load      = (state == STREAM) && (!valid_q || bus.idx_ready_i);
   assign last_elem = (elem_cnt == num_q);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         num_q      <= BITS_PER_ELEMENT'(MAX_ELEMENTS - 1);
         elem_cnt   <= '0;
         data_q     <= '0;
         pass_cnt   <= '0;
         pass_lim   <= '0;
         perm_ready <= 1'b0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // A completion arriving in the same cycle REQ consumes the flag is kept.
         if (state == LOAD)
            perm_ready <= 1'b0;
         else if (bus.perm_done_i && state != IDLE)
            perm_ready <= 1'b1;
         else if (state == REQ)
            perm_ready <= 1'b0;

         if (bus.abort_i) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            elem_cnt <= '0;
         end else begin
            case (state)
               IDLE: if (bus.cfg_valid_i) begin
                  num_q    <= bus.cfg_num_i;
                  pass_lim <= bus.cfg_passes_i;
                  pass_cnt <= '0;
                  state    <= LOAD;
               end
               LOAD:      state <= WAIT_PERM;
               WAIT_PERM: if (perm_ready) state <= REQ;
               REQ: begin
                  elem_cnt <= '0;
                  state    <= SETTLE;
               end
               SETTLE:    state <= STREAM;
               STREAM: if (load) begin
                  data_q   <= bus.data_i;
                  last_q   <= last_elem;
                  valid_q  <= 1'b1;
                  elem_cnt <= elem_cnt + 1'b1;
                  if (last_elem) state <= DRAIN;
               end
               DRAIN: if (bus.idx_ready_i) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (pass_cnt == pass_lim) begin
                     done_q <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     pass_cnt <= pass_cnt + 1'b1;
                     state    <= WAIT_PERM;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.cfg_ready_o    = (state == IDLE);
   assign bus.rst_index_o    = (state == LOAD);
   assign bus.perm_req_o     = (state == REQ);
   assign bus.addr_o         = (state == STREAM) ? elem_cnt : '0;
   assign bus.num_elements_o = num_q;
   assign bus.idx_valid_o    = valid_q;
   assign bus.idx_data_o     = data_q;
   assign bus.idx_last_o     = last_q;
   assign bus.done_o         = done_q;
   assign dbg_state          = state;
endmodule
